arm_dmem_io: RTL and testbench
==============================

# arm_dmem_io

Data-memory responder for the single-cycle ARM core's data port: answers the core's address / write-data / write-enable / read-data interface. Maps a word RAM plus a small memory-mapped I/O page: a transmit byte FIFO drained by an external consumer, a status register, and a free-running cycle counter. Reads are combinational so the single-cycle core completes loads in-cycle. Writes commit on the rising clock edge.

## Interface
- `RAM_WORDS`, default 64: number of 32-bit RAM words; power of two.
- `FIFO_DEPTH`, default 8: transmit FIFO entries; power of two, ≥2, ≤128.
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high.
- `a` in 32: byte address (driven by core ALUResult).
- `wd` in 32: write data (core WriteData).
- `we` in 1: write enable (core MemWrite).
- `rd` out 32: read data (core ReadData), combinational from `a` and state.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: consumer accepts head this cycle.

## Operation
- Address decode, `a[1:0]` ignored everywhere:
  - RAM: `a < 4*RAM_WORDS`; word index `a[log2(RAM_WORDS)+1:2]`. Read returns word; write stores `wd`.
  - `0xFFFF_0000` TXDATA: write pushes `wd[7:0]`; read returns 0.
  - `0xFFFF_0004` STATUS: read `{16'b0, count[7:0], 5'b0, overflow, full, empty}`; any write clears `overflow`.
  - `0xFFFF_0008` CYCLES: read counter; write loads `wd`.
  - All other addresses: read 0, write ignored.
- Push when full: byte dropped, `overflow` set (sticky).
- Pop: on edge where `tx_valid && tx_ready`; head advances.
- Full and pop in same cycle as push: push accepted, count unchanged.
- Overflow set and STATUS write in same cycle: set wins.
- Empty and push in same cycle: no pop possible (`tx_valid`=0); count becomes 1.
- Counter increments by 1 every cycle, wraps `0xFFFF_FFFF`→0. Write to CYCLES loads `wd` next cycle; load beats increment.

## Timing
- Reset values: FIFO empty (`tx_valid`=0, `tx_data`=0, count 0), `overflow`=0, counter 0. RAM contents are not cleared.
- `rd` is valid in the same cycle as `a`: zero-cycle read latency. It reflects state before any same-cycle write, so there is no write-through.
- A byte pushed at edge N into an empty FIFO gives `tx_valid`=1 and `tx_data` = that byte after edge N.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- STATUS read after push at edge N shows the updated count from cycle N+1.
- Reset asserted mid-stream discards all FIFO contents and `overflow` at the next edge. Pushes and pops in that cycle are ignored.
- Counter reads N in the cycle after reset release, then N+1, and so on, with N=0.

## Configuration
- `DMEM_CYCLE_COUNTER_EN`:
  - Defined: CYCLES register implemented as above.
  - Undefined: no counter flops; CYCLES reads 0 and writes to it are ignored. All other behaviour is unchanged.

## Structure
- Package `dmem_pkg` holds:
  - Address constants `TXDATA_ADDR`, `STATUS_ADDR`, `CYCLES_ADDR`, `IO_BASE`.
  - STATUS bit indices `ST_EMPTY`=0, `ST_FULL`=1, `ST_OVF`=2, `ST_COUNT_LSB`=8.
- Sub-module `sync_fifo`: parameterised width/depth, push/pop/full/empty/count, same-cycle push+pop when full allowed.
- Top holds decode, RAM array, status/counter registers, and the read mux.

## Test plan
- RAM write/read: reset; write `0x1234_5678` to 0x10, read 0x10 and 0x13 → both `0x1234_5678`. Read 0x14 before any write → no X propagation assumed checked only after write.
- FIFO order: `tx_ready`=0, push 0xA1,0xB2,0xC3 → STATUS=`0x0000_0300`; raise `tx_ready` → `tx_data` A1,B2,C3 on consecutive cycles, then `tx_valid`=0, STATUS=`0x0000_0001`.
- Overflow: push 9 bytes (DEPTH 8, no drain) → STATUS=`0x0000_0806`, ninth byte absent. Write STATUS → bit 2 clears. Push-when-full with `tx_ready`=1 → accepted, count stays 8.
- Counter: after reset read CYCLES on cycle k → k. Write `0xFFFF_FFFE` → next reads `0xFFFF_FFFE`, `0xFFFF_FFFF`, 0. Without `DMEM_CYCLE_COUNTER_EN` → always 0.
- Unmapped/reset: write `0xDEAD` to `0xFFFF_000C` → reads 0. Assert reset with 3 bytes queued → `tx_valid`=0, STATUS=`0x0000_0001` next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: I/O page addresses and STATUS bit layout.
package dmem_pkg;

  localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
  localparam logic [31:0] TXDATA_ADDR = IO_BASE + 32'h0;
  localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'h4;
  localparam logic [31:0] CYCLES_ADDR = IO_BASE + 32'h8;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  // Byte lanes are ignored by every decode, so compare on the word-aligned address.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted when a pop
// happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0]   ONE_C    = 1;
  localparam logic [PW-1:0] ONE_P    = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [PW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // Head is forced to zero when empty so the output is defined straight out of reset.
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ONE_P;
      if (w_pop)  r_rptr <= r_rptr + ONE_P;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/arm_dmem_io.sv
// Data-memory responder for the single-cycle ARM core: word RAM plus TXDATA/STATUS/CYCLES I/O page.
// Define DMEM_CYCLE_COUNTER_EN to implement the free-running CYCLES counter (reads 0 otherwise).
module arm_dmem_io
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0]   r_ram [RAM_WORDS];
  logic          r_ovf;
  logic [31:0]   w_waddr;
  logic [AW-1:0] w_idx;
  logic          w_is_ram;
  logic          w_is_tx;
  logic          w_is_st;
  logic          w_is_cyc;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_cycles;

  assign w_waddr  = word_addr(a);
  assign w_idx    = a[AW+1:2];
  assign w_is_ram = (a < RAM_BYTES);
  assign w_is_tx  = (w_waddr == TXDATA_ADDR);
  assign w_is_st  = (w_waddr == STATUS_ADDR);
  assign w_is_cyc = (w_waddr == CYCLES_ADDR);
  assign w_push   = we && w_is_tx;
  assign tx_valid = !w_empty;

  always_ff @(posedge clk) begin
    if (we && w_is_ram) r_ram[w_idx] <= wd;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txfifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (wd[7:0]),
    .i_pop   (tx_ready),
    .o_dout  (tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A dropped push sets overflow even if STATUS is written on the same edge.
  always_ff @(posedge clk) begin
    if (reset)                            r_ovf <= 1'b0;
    else if (w_push && w_full && !tx_ready) r_ovf <= 1'b1;
    else if (we && w_is_st)               r_ovf <= 1'b0;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;

  always_ff @(posedge clk) begin
    if (reset)               r_cycles <= '0;
    else if (we && w_is_cyc) r_cycles <= wd;
    else                     r_cycles <= r_cycles + 32'd1;
  end

  assign w_cycles = r_cycles;
`else
  assign w_cycles = '0;
`endif

  always_comb begin
    w_status               = '0;
    w_status[ST_EMPTY]     = w_empty;
    w_status[ST_FULL]      = w_full;
    w_status[ST_OVF]       = r_ovf;
    w_status[ST_COUNT_LSB +: 8] = 8'(w_count);
  end

  // Combinational read of pre-edge state: no write-through.
  always_comb begin
    rd = '0;
    if (w_is_ram)      rd = r_ram[w_idx];
    else if (w_is_st)  rd = w_status;
    else if (w_is_cyc) rd = w_cycles;
  end

endmodule

// File: tb/tb_arm_dmem_io.sv
// Bench for arm_dmem_io: queue-based reference model checked every cycle plus literal expectations.
module tb_arm_dmem_io;

  localparam int DEPTH = 8;
  localparam logic [31:0] TX  = 32'hFFFF_0000;
  localparam logic [31:0] ST  = 32'hFFFF_0004;
  localparam logic [31:0] CYC = 32'hFFFF_0008;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic        we = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0]  q[$];
  bit          m_ovf = 1'b0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ram [int];
  bit          m_live = 1'b0;

  arm_dmem_io #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .rd(rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_rd(input logic [31:0] addr, output logic [31:0] v);
    logic [31:0] w;
    w = {addr[31:2], 2'b00};
    v = '0;
    if (w < 32'd256) begin
      if (m_ram.exists(int'(w))) begin
        v = m_ram[int'(w)];
        return 1'b1;
      end
      return 1'b0;
    end
    if (w == ST)
      v = {16'h0, 8'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
    else if (w == CYC)
      v = CNT_EN ? m_cyc : 32'h0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [31:0] w;
    bit pop;
    bit set_ovf;
    w = {a[31:2], 2'b00};
    set_ovf = 1'b0;
    if (reset) begin
      q.delete();
      m_ovf  = 1'b0;
      m_cyc  = '0;
      m_live = 1'b1;
    end else begin
      pop = tx_ready && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (we && w == TX) begin
        if (q.size() < DEPTH) q.push_back(wd[7:0]);
        else set_ovf = 1'b1;
      end
      if (set_ovf) m_ovf = 1'b1;
      else if (we && w == ST) m_ovf = 1'b0;
      if (we && w < 32'd256) m_ram[int'(w)] = wd;
      m_cyc = (we && w == CYC) ? wd : m_cyc + 32'd1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [31:0] v;
    @(negedge clk);
    if (m_live) begin
      if (model_rd(a, v)) chk("rd_model", rd, v);
      chk("tx_valid_model", {31'b0, tx_valid}, {31'b0, q.size() != 0});
      chk("tx_data_model", {24'b0, tx_data}, (q.size() != 0) ? {24'b0, q[0]} : 32'h0);
    end
  end

  task automatic step(input logic r, input logic [31:0] ad, input logic [31:0] d,
                      input logic w, input logic rdy);
    @(posedge clk);
    #1;
    reset = r; a = ad; wd = d; we = w; tx_ready = rdy;
  endtask

  task automatic rdchk(input string n, input logic [31:0] ad, input logic [31:0] exp);
    step(1'b0, ad, 32'h0, 1'b0, 1'b0);
    #1;
    chk(n, rd, exp);
  endtask

  initial begin
    logic [7:0] drain_exp [8];
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset state and counter start
    rdchk("cyc_k0", CYC, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    rdchk("cyc_k1", CYC, CNT_EN ? 32'h1 : 32'h0);
    rdchk("rst_status", ST, 32'h0000_0001);

    // RAM
    step(1'b0, 32'h10, 32'h1234_5678, 1'b1, 1'b0);
    rdchk("ram_10", 32'h10, 32'h1234_5678);
    rdchk("ram_13", 32'h13, 32'h1234_5678);
    step(1'b0, 32'h0, 32'hCAFE_0000, 1'b1, 1'b0);
    step(1'b0, 32'h100, 32'h0000_0BAD, 1'b1, 1'b0);
    rdchk("ram_0_no_alias", 32'h0, 32'hCAFE_0000);
    rdchk("ram_oob", 32'h100, 32'h0);

    // FIFO ordering
    step(1'b0, TX, 32'hA1, 1'b1, 1'b0);
    step(1'b0, TX, 32'hB2, 1'b1, 1'b0);
    step(1'b0, TX, 32'hC3, 1'b1, 1'b0);
    rdchk("st_three", ST, 32'h0000_0300);
    chk("head_a1", {24'b0, tx_data}, 32'hA1);
    rdchk("txdata_read0", TX, 32'h0);
    step(1'b0, ST, 32'h0, 1'b0, 1'b1); #1; chk("pop_a1", {24'b0, tx_data}, 32'hA1);
    step(1'b0, ST, 32'h0, 1'b0, 1'b1); #1; chk("pop_b2", {24'b0, tx_data}, 32'hB2);
    step(1'b0, ST, 32'h0, 1'b0, 1'b1); #1; chk("pop_c3", {24'b0, tx_data}, 32'hC3);
    rdchk("st_empty", ST, 32'h0000_0001);
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);

    // Overflow
    for (int i = 1; i <= 9; i++) step(1'b0, TX, 32'(i), 1'b1, 1'b0);
    rdchk("st_ovf", ST, 32'h0000_0806);
    step(1'b0, ST, 32'h0, 1'b1, 1'b0);
    rdchk("st_ovf_clr", ST, 32'h0000_0802);
    step(1'b0, TX, 32'h0A, 1'b1, 1'b1);
    rdchk("st_full_pop", ST, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      #1;
      chk("drain_order", {24'b0, tx_data}, {24'b0, drain_exp[i]});
    end
    rdchk("st_after_drain", ST, 32'h0000_0001);

    // Push into empty FIFO while consumer is ready
    step(1'b0, TX, 32'h77, 1'b1, 1'b1);
    rdchk("st_empty_push", ST, 32'h0000_0100);
    chk("head_77", {24'b0, tx_data}, 32'h77);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Counter load and wrap
    step(1'b0, CYC, 32'hFFFF_FFFE, 1'b1, 1'b0);
    rdchk("cyc_load", CYC, CNT_EN ? 32'hFFFF_FFFE : 32'h0);
    rdchk("cyc_max", CYC, CNT_EN ? 32'hFFFF_FFFF : 32'h0);
    rdchk("cyc_wrap", CYC, 32'h0);

    // Unmapped
    step(1'b0, 32'hFFFF_000C, 32'h0000_DEAD, 1'b1, 1'b0);
    rdchk("unmapped", 32'hFFFF_000C, 32'h0);

    // Reset mid-stream with push and pop presented
    step(1'b0, TX, 32'h11, 1'b1, 1'b0);
    step(1'b0, TX, 32'h22, 1'b1, 1'b0);
    step(1'b0, TX, 32'h33, 1'b1, 1'b0);
    step(1'b1, TX, 32'h55, 1'b1, 1'b1);
    rdchk("st_mid_reset", ST, 32'h0000_0001);
    chk("mid_reset_valid", {31'b0, tx_valid}, 32'h0);
    rdchk("ram_keeps", 32'h10, 32'h1234_5678);

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
